// File: rtl/palette_lut_mp.sv
// Multi-port palette LUT: NREAD registered video read ports, CPU index/data pair, init sweep.
// Optional macro PALETTE_LUT_BYPASS_EN selects write-first forwarding on read/write collisions.
module palette_lut_mp #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int NREAD  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      idx_we,
   input  logic                      dat_we,
   input  logic                      autoinc,
   input  logic                      clr,
   input  logic [DATA_W-1:0]         din,
   output logic [ADDR_W-1:0]         idx,
   output logic [DATA_W-1:0]         cpu_dout,
   output logic                      busy,
   input  logic [NREAD*ADDR_W-1:0]   ra,
   output logic [NREAD*DATA_W-1:0]   rd
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   cnt_r, cnt_s;
   logic [ADDR_W-1:0]   idx_r, idx_s;
   logic                busy_r, busy_s;
   logic                we_s;
   logic [ADDR_W-1:0]   wa_s;
   logic [DATA_W-1:0]   wd_s;
   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [NREAD*DATA_W-1:0] rd_r, rd_s;
   logic [DATA_W-1:0]   cpu_dout_r, cpu_dout_s;

   // Default entry value: index zero-extended or truncated to the entry width.
   function automatic logic [DATA_W-1:0] default_entry(input logic [ADDR_W-1:0] i);
      return DATA_W'(i);
   endfunction

   function automatic logic [ADDR_W-1:0] din_to_idx(input logic [DATA_W-1:0] d);
      return ADDR_W'(d);
   endfunction

   // Next-state, index update and single write-port selection.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      busy_s  = busy_r;
      we_s    = 1'b0;
      wa_s    = idx_r;
      wd_s    = din;
      if (rst || clr) begin
         state_s = ST_INIT;
         cnt_s   = {ADDR_W{1'b0}};
         busy_s  = 1'b1;
      end else begin
         case (state_r)
            ST_INIT: begin
               we_s  = 1'b1;
               wa_s  = cnt_r;
               wd_s  = default_entry(cnt_r);
               cnt_s = cnt_r + ADDR_W'(1);
               if (cnt_r == {ADDR_W{1'b1}}) begin
                  state_s = ST_IDLE;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_INIT;
                  busy_s  = 1'b1;
               end
            end
            ST_IDLE: begin
               // idx_we wins; a coincident dat_we is dropped.
               if (idx_we) begin
                  idx_s = din_to_idx(din);
               end else if (dat_we) begin
                  we_s = 1'b1;
                  if (autoinc) begin
                     idx_s = idx_r + ADDR_W'(1);
                  end else begin
                     idx_s = idx_r;
                  end
               end else begin
                  idx_s = idx_r;
               end
            end
            default: begin
               state_s = ST_INIT;
               cnt_s   = {ADDR_W{1'b0}};
               busy_s  = 1'b1;
            end
         endcase
      end
   end

   // Read data selection for all video ports and the CPU readback.
   always_comb begin
      rd_s = {(NREAD*DATA_W){1'b0}};
      for (int k = 0; k < NREAD; k++) begin
`ifdef PALETTE_LUT_BYPASS_EN
         if (we_s && (wa_s == ra[k*ADDR_W +: ADDR_W])) begin
            rd_s[k*DATA_W +: DATA_W] = wd_s;
         end else begin
            rd_s[k*DATA_W +: DATA_W] = mem_r[ra[k*ADDR_W +: ADDR_W]];
         end
`else
         rd_s[k*DATA_W +: DATA_W] = mem_r[ra[k*ADDR_W +: ADDR_W]];
`endif
      end
`ifdef PALETTE_LUT_BYPASS_EN
      if (we_s && (wa_s == idx_r)) begin
         cpu_dout_s = wd_s;
      end else begin
         cpu_dout_s = mem_r[idx_r];
      end
`else
      cpu_dout_s = mem_r[idx_r];
`endif
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_INIT;
         cnt_r   <= {ADDR_W{1'b0}};
         idx_r   <= {ADDR_W{1'b0}};
         busy_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         busy_r  <= busy_s;
      end
   end

   // Palette storage; contents are established by the init sweep, not by reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[wa_s] <= wd_s;
      end
   end

   // Registered read ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_r       <= {(NREAD*DATA_W){1'b0}};
         cpu_dout_r <= {DATA_W{1'b0}};
      end else begin
         rd_r       <= rd_s;
         cpu_dout_r <= cpu_dout_s;
      end
   end

   assign idx      = idx_r;
   assign cpu_dout = cpu_dout_r;
   assign busy     = busy_r;
   assign rd       = rd_r;

endmodule
